// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO and runs multicycle mult/div
// with independent latencies, and generates the D-stage stall while busy.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             d_md_use,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] md_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  logic [WIDTH-1:0]   hi_r, lo_r, a_r, b_r;
  logic [2:0]         op_r;
  logic [CW-1:0]      cnt_r;

  logic [WIDTH-1:0]   hi_nxt_s, lo_nxt_s, a_nxt_s, b_nxt_s;
  logic [2:0]         op_nxt_s;
  logic [CW-1:0]      cnt_nxt_s;
  logic               busy_s;

  logic               sgn_mul_s, a_neg_s, b_neg_s;
  logic [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, q_mag_s, r_mag_s, quo_s, rem_s;
  logic [WIDTH-1:0]   md_out_s;

  assign busy_s = (cnt_r != {CW{1'b0}});

  // Result datapath from the latched operands; only sampled on the commit edge.
  always_comb begin
    sgn_mul_s = (op_r == OP_MULT);
    a_ext_s   = {{WIDTH{a_r[WIDTH-1] & sgn_mul_s}}, a_r};
    b_ext_s   = {{WIDTH{b_r[WIDTH-1] & sgn_mul_s}}, b_r};
    prod_s    = a_ext_s * b_ext_s;
    a_neg_s   = (op_r == OP_DIV) & a_r[WIDTH-1];
    b_neg_s   = (op_r == OP_DIV) & b_r[WIDTH-1];
    a_mag_s   = a_neg_s ? (~a_r + {{(WIDTH-1){1'b0}}, 1'b1}) : a_r;
    b_mag_s   = b_neg_s ? (~b_r + {{(WIDTH-1){1'b0}}, 1'b1}) : b_r;
    // Magnitude form also covers most-negative / -1: quotient wraps back to most-negative.
    if (b_r != {WIDTH{1'b0}}) begin
      q_mag_s = a_mag_s / b_mag_s;
      r_mag_s = a_mag_s % b_mag_s;
    end else begin
      q_mag_s = {WIDTH{1'b0}};
      r_mag_s = {WIDTH{1'b0}};
    end
    quo_s = (a_neg_s ^ b_neg_s) ? (~q_mag_s + {{(WIDTH-1){1'b0}}, 1'b1}) : q_mag_s;
    rem_s = a_neg_s ? (~r_mag_s + {{(WIDTH-1){1'b0}}, 1'b1}) : r_mag_s;
  end

  // Next-state: count down and commit while busy, otherwise accept a new op.
  always_comb begin
    hi_nxt_s  = hi_r;
    lo_nxt_s  = lo_r;
    a_nxt_s   = a_r;
    b_nxt_s   = b_r;
    op_nxt_s  = op_r;
    cnt_nxt_s = cnt_r;
    if (busy_s) begin
      cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
      if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
        case (op_r)
          OP_MULT, OP_MULTU: {hi_nxt_s, lo_nxt_s} = prod_s;
          OP_DIV, OP_DIVU: begin
            if (b_r != {WIDTH{1'b0}}) begin
              hi_nxt_s = rem_s;
              lo_nxt_s = quo_s;
            end else begin
              hi_nxt_s = hi_r;
              lo_nxt_s = lo_r;
            end
          end
          default: ;
        endcase
      end else begin
        hi_nxt_s = hi_r;
      end
    end else if (start) begin
      case (md_op)
        OP_MULT, OP_MULTU: begin
          a_nxt_s   = a;
          b_nxt_s   = b;
          op_nxt_s  = md_op;
          cnt_nxt_s = CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          a_nxt_s   = a;
          b_nxt_s   = b;
          op_nxt_s  = md_op;
          cnt_nxt_s = CW'(DIV_CYCLES);
        end
        OP_MTHI: hi_nxt_s = a;
        OP_MTLO: lo_nxt_s = a;
        default: ;
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      op_r  <= 3'd0;
      cnt_r <= {CW{1'b0}};
    end else begin
      hi_r  <= hi_nxt_s;
      lo_r  <= lo_nxt_s;
      a_r   <= a_nxt_s;
      b_r   <= b_nxt_s;
      op_r  <= op_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // mf read path: unforwarded registered HI/LO, zero when no mf is selected.
  always_comb begin
    md_out_s = {WIDTH{1'b0}};
    if (start && (md_op == OP_MFHI)) begin
      md_out_s = hi_r;
    end else if (start && (md_op == OP_MFLO)) begin
      md_out_s = lo_r;
    end else begin
      md_out_s = {WIDTH{1'b0}};
    end
  end

  assign busy   = busy_s;
  assign stall  = d_md_use & (busy_s | (start & ~md_op[2]));
  assign md_out = md_out_s;
  assign hi     = hi_r;
  assign lo     = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a 32-bit 5/10-cycle instance and a 16-bit 1/1-cycle
// instance share the same stimulus; each task checks its own scenario.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        d_md_use;
  logic        busy, stall;
  logic [31:0] md_out, hi, lo;
  logic        s_busy, s_stall;
  logic [15:0] s_md_out, s_hi, s_lo;

  int checks   = 0;
  int failures = 0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .d_md_use(d_md_use), .busy(busy), .stall(stall), .md_out(md_out),
    .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_small (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a[15:0]), .b(b[15:0]),
    .d_md_use(d_md_use), .busy(s_busy), .stall(s_stall), .md_out(s_md_out),
    .hi(s_hi), .lo(s_lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] v);
    start = 1'b1; md_op = op; a = v; b = 32'h0;
    step();
    start = 1'b0;
  endtask

  // Issue one mult/div and count the cycles busy stays high (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input bit use_small, output int n);
    start = 1'b1; md_op = op; a = av; b = bv;
    step();
    start = 1'b0;
    n = 0;
    while (((use_small ? s_busy : busy) === 1'b1) && (n < 100)) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; md_op = 3'd0; a = 32'h0; b = 32'h0; d_md_use = 1'b0;
    #2;
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (md_out !== 32'h0) begin failures++; $display("FAIL reset_md_out got=%h exp=0", md_out); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_mt_mf();
    start = 1'b1; md_op = 3'd6; a = 32'h12345678;
    #1;
    checks++; if (md_out !== 32'h0) begin failures++; $display("FAIL mt_md_out got=%h exp=0", md_out); end
    step();
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi got=%h exp=12345678", hi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    md_op = 3'd7; a = 32'h9ABCDEF0;
    step();
    checks++; if (lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo got=%h exp=9abcdef0", lo); end
    md_op = 3'd4;
    #1;
    checks++; if (md_out !== 32'h12345678) begin failures++; $display("FAIL mfhi got=%h exp=12345678", md_out); end
    md_op = 3'd5;
    #1;
    checks++; if (md_out !== 32'h9ABCDEF0) begin failures++; $display("FAIL mflo got=%h exp=9abcdef0", md_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mf_busy got=%b exp=0", busy); end
    start = 1'b0;
    #1;
    checks++; if (md_out !== 32'h0) begin failures++; $display("FAIL mf_nostart got=%h exp=0", md_out); end
    step();
  endtask

  task automatic test_mult();
    int n;
    run_op(3'd0, 32'hFFFFFFFE, 32'h3, 1'b0, n);
    checks++; if (n != 5) begin failures++; $display("FAIL mult_busy_len got=%0d exp=5", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    run_op(3'd1, 32'hFFFFFFFE, 32'h3, 1'b0, n);
    checks++; if (n != 5) begin failures++; $display("FAIL multu_busy_len got=%0d exp=5", n); end
    checks++; if (hi !== 32'h00000002) begin failures++; $display("FAIL multu_hi got=%h exp=00000002", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_div();
    int n;
    run_op(3'd2, 32'hFFFFFFF9, 32'h2, 1'b0, n);
    checks++; if (n != 10) begin failures++; $display("FAIL div_busy_len got=%0d exp=10", n); end
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    run_op(3'd3, 32'h7, 32'h2, 1'b0, n);
    checks++; if (lo !== 32'h3) begin failures++; $display("FAIL divu_lo got=%h exp=3", lo); end
    checks++; if (hi !== 32'h1) begin failures++; $display("FAIL divu_hi got=%h exp=1", hi); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, n);
    checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
  endtask

  task automatic test_div_zero();
    int n;
    do_mt(3'd6, 32'hAAAA);
    do_mt(3'd7, 32'h5555);
    run_op(3'd2, 32'h5, 32'h0, 1'b0, n);
    checks++; if (n != 10) begin failures++; $display("FAIL divz_busy_len got=%0d exp=10", n); end
    checks++; if (hi !== 32'hAAAA) begin failures++; $display("FAIL divz_hi got=%h exp=0000aaaa", hi); end
    checks++; if (lo !== 32'h5555) begin failures++; $display("FAIL divz_lo got=%h exp=00005555", lo); end
    run_op(3'd3, 32'h9, 32'h0, 1'b0, n);
    checks++; if ({hi, lo} !== {32'hAAAA, 32'h5555}) begin failures++; $display("FAIL divuz_hilo got=%h_%h exp=0000aaaa_00005555", hi, lo); end
  endtask

  task automatic test_stall();
    d_md_use = 1'b1;
    start = 1'b1; md_op = 3'd0; a = 32'h3; b = 32'h4;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_start got=%b exp=1", stall); end
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({busy, stall} !== 2'b11) begin failures++; $display("FAIL stall_busy_c%0d got=%b exp=11", i, {busy, stall}); end
      if (i == 2) begin
        start = 1'b1; md_op = 3'd6; a = 32'hDEAD;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    #1;
    checks++; if ({busy, stall} !== 2'b00) begin failures++; $display("FAIL stall_after got=%b exp=00", {busy, stall}); end
    checks++; if ({hi, lo} !== {32'h0, 32'hC}) begin failures++; $display("FAIL stall_inject_hilo got=%h_%h exp=00000000_0000000c", hi, lo); end
    d_md_use = 1'b0;
  endtask

  task automatic test_reset_abort();
    do_mt(3'd6, 32'h1111);
    start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++; if ({busy, hi, lo} !== 65'h0) begin failures++; $display("FAIL abort_now got=%b_%h_%h exp=0", busy, hi, lo); end
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++; if ({busy, hi, lo} !== 65'h0) begin failures++; $display("FAIL abort_later got=%b_%h_%h exp=0", busy, hi, lo); end
  endtask

  task automatic test_small();
    int n;
    start = 1'b1; md_op = 3'd0; a = 32'hFFFFFFFE; b = 32'h3;
    step();
    start = 1'b0;
    checks++; if ({s_busy, s_lo} !== {1'b1, 16'h0}) begin failures++; $display("FAIL small_mult_busy got=%b_%h exp=1_0000", s_busy, s_lo); end
    step();
    checks++; if ({s_busy, s_hi, s_lo} !== {1'b0, 16'hFFFF, 16'hFFFA}) begin failures++; $display("FAIL small_mult got=%b_%h_%h exp=0_ffff_fffa", s_busy, s_hi, s_lo); end
    run_op(3'd1, 32'h0000FFFE, 32'h3, 1'b1, n);
    checks++; if (n != 1) begin failures++; $display("FAIL small_busy_len got=%0d exp=1", n); end
    checks++; if ({s_hi, s_lo} !== {16'h0002, 16'hFFFA}) begin failures++; $display("FAIL small_multu got=%h_%h exp=0002_fffa", s_hi, s_lo); end
    run_op(3'd2, 32'h0000FFF9, 32'h2, 1'b1, n);
    checks++; if ({s_hi, s_lo} !== {16'hFFFF, 16'hFFFD}) begin failures++; $display("FAIL small_div got=%h_%h exp=ffff_fffd", s_hi, s_lo); end
    run_op(3'd2, 32'h00008000, 32'h0000FFFF, 1'b1, n);
    checks++; if ({s_hi, s_lo} !== {16'h0000, 16'h8000}) begin failures++; $display("FAIL small_div_ovf got=%h_%h exp=0000_8000", s_hi, s_lo); end
    run_op(3'd3, 32'h7, 32'h0, 1'b1, n);
    checks++; if ({n[3:0], s_hi, s_lo} !== {4'd1, 16'h0000, 16'h8000}) begin failures++; $display("FAIL small_divz got=%0d_%h_%h exp=1_0000_8000", n, s_hi, s_lo); end
    run_op(3'd3, 32'h7, 32'h2, 1'b1, n);
    checks++; if ({s_hi, s_lo} !== {16'h0001, 16'h0003}) begin failures++; $display("FAIL small_divu got=%h_%h exp=0001_0003", s_hi, s_lo); end
  endtask

  initial begin
    test_reset();
    test_mt_mf();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_reset_abort();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
